// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg
//
// Shared definitions for the PDM microphone decimator:
//   CIC_ORDER        number of integrator / comb stages in the CIC filter
//   DEFAULT_CLK_DIV  system clocks per PDM bit
//   DEFAULT_DECIM    PDM bits per output PCM sample
//   sample_t         16-bit signed PCM sample
//   cic_width()      internal CIC register width for a decimation ratio
//   cic_shift()      right shift that scales the CIC gain to 16 bits
//
// No ports (package).
// ---------------------------------------------------------------------------
package pdm_pkg;

  localparam int CIC_ORDER       = 3;
  localparam int DEFAULT_CLK_DIV = 16;
  localparam int DEFAULT_DECIM   = 64;

  typedef logic signed [15:0] sample_t;

  // The CIC gain is DECIM^ORDER and the +/-1 input needs two bits, so this
  // width holds the full-scale comb output without ambiguity. The
  // integrators are allowed to wrap; the combs undo the wrap exactly.
  function automatic int cic_width(input int decim);
    return CIC_ORDER * $clog2(decim) + 2;
  endfunction

  // Full-scale comb output is +/-2^(ORDER*log2(DECIM)); shifting by this
  // amount maps it onto +/-2^15.
  function automatic int cic_shift(input int decim);
    return CIC_ORDER * $clog2(decim) - 15;
  endfunction

endpackage

// File: rtl/pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// pdm_cic_decimator
//
// Third-order CIC decimator for a 1-bit PDM stream. Each accepted bit is
// mapped to +1 / -1, accumulated by three cascaded integrators, decimated by
// DECIM, differentiated by three combs (differential delay 1), scaled down
// by an arithmetic shift and saturated to a signed 16-bit sample.
//
// Parameters:
//   DECIM             PDM bits per output sample (power of two, >= 32)
//
// Ports:
//   clk_in            system clock, rising edge
//   rst_in            synchronous active-high reset, clears all filter state
//   bit_strobe        one-cycle pulse: bit_value is a new PDM bit
//   bit_value         the PDM bit accepted on bit_strobe
//   sample_out        registered 16-bit signed sample, held between updates
//   sample_valid_out  one-cycle pulse, two cycles after the bit strobe that
//                     completed a decimation period
// ---------------------------------------------------------------------------
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int DECIM = DEFAULT_DECIM
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               bit_strobe,
  input  logic               bit_value,
  output logic signed [15:0] sample_out,
  output logic               sample_valid_out
);

  localparam int LOG2_DECIM = $clog2(DECIM);
  localparam int W          = cic_width(DECIM);
  localparam int SHIFT      = cic_shift(DECIM);

  localparam logic signed [W-1:0] SAT_HI = W'(32767);
  localparam logic signed [W-1:0] SAT_LO = W'(-32768);

  logic signed [W-1:0]    step_val;
  logic signed [W-1:0]    integ1;
  logic signed [W-1:0]    integ2;
  logic signed [W-1:0]    integ3;
  logic [LOG2_DECIM-1:0]  dec_cnt;
  logic                   comb_go;

  logic signed [W-1:0]    comb_d1;
  logic signed [W-1:0]    comb_d2;
  logic signed [W-1:0]    comb_d3;
  logic signed [W-1:0]    comb1;
  logic signed [W-1:0]    comb2;
  logic signed [W-1:0]    comb3;
  logic signed [W-1:0]    scaled;
  sample_t                sat_sample;

  // Map the PDM bit onto the two-level input of the filter: 1 -> +1 and
  // 0 -> -1 (all ones in two's complement).
  always_comb begin
    step_val = bit_value ? W'(1) : '1;
  end

  // Integrator chain and decimation counter. Every integrator adds the
  // previous cycle's value of the stage before it, which keeps each adder
  // registered on its own; this only delays the response by two bits and
  // does not change the DC gain. All adds wrap modulo 2^W on purpose.
  // comb_go marks the bit that closed a period; the combs then run on the
  // following cycle, using the integrator value that includes that bit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      integ1  <= '0;
      integ2  <= '0;
      integ3  <= '0;
      dec_cnt <= '0;
      comb_go <= 1'b0;
    end else begin
      comb_go <= 1'b0;
      if (bit_strobe) begin
        integ1  <= integ1 + step_val;
        integ2  <= integ2 + integ1;
        integ3  <= integ3 + integ2;
        dec_cnt <= dec_cnt + 1'b1;
        comb_go <= (dec_cnt == '1);
      end
    end
  end

  // Comb chain, scaling and saturation. The differences are taken at the
  // decimated rate, so each comb's delay register holds the previous
  // decimated value of its own input. Only the exact positive full-scale
  // case (+32768) can overflow 16 bits in practice, but both rails are
  // clamped so that any parameter choice stays safe.
  always_comb begin
    comb1  = integ3 - comb_d1;
    comb2  = comb1 - comb_d2;
    comb3  = comb2 - comb_d3;
    scaled = comb3 >>> SHIFT;
    if (scaled > SAT_HI) begin
      sat_sample = 16'sh7FFF;
    end else if (scaled < SAT_LO) begin
      sat_sample = 16'sh8000;
    end else begin
      sat_sample = scaled[15:0];
    end
  end

  // Comb delay registers and the output register. The sample holds its
  // value until the next decimated result; the valid strobe lasts one
  // cycle and there is no handshake, so a consumer that misses it loses
  // that sample.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      comb_d1          <= '0;
      comb_d2          <= '0;
      comb_d3          <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= comb_go;
      if (comb_go) begin
        comb_d1    <= integ3;
        comb_d2    <= comb1;
        comb_d3    <= comb2;
        sample_out <= sat_sample;
      end
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// ---------------------------------------------------------------------------
// pdm_decimator
//
// PDM microphone front end: generates the PDM bit clock, synchronises the
// incoming PDM stream, produces one bit strobe per PDM bit and feeds the CIC
// decimator. An optional first-order DC blocker follows the CIC filter.
//
// Optional feature (compile-time macro):
//   PDM_DECIMATOR_DCBLOCK_EN  when defined, a DC blocker
//                             y = x - x_prev + y_prev - (y_prev >>> 8)
//                             processes every sample; this adds one cycle
//                             of latency to sample_valid_out.
//
// Parameters:
//   CLK_DIV           system clocks per PDM bit (even, >= 4)
//   DECIM             PDM bits per output sample (power of two, >= 32)
//
// Ports:
//   clk_in            system clock, rising edge
//   rst_in            synchronous active-high reset
//   pdm_in            asynchronous 1-bit PDM data from the microphone
//   pdm_clk_out       registered PDM bit clock, 50% duty cycle
//   sample_out        signed 16-bit PCM sample, held between strobes
//   sample_valid_out  one-cycle strobe marking a new sample_out
// ---------------------------------------------------------------------------
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DECIM   = DEFAULT_DECIM
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               pdm_in,
  output logic               pdm_clk_out,
  output logic signed [15:0] sample_out,
  output logic               sample_valid_out
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int HALF  = CLK_DIV / 2;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             pdm_meta;
  logic             pdm_sync;
  logic             bit_strobe;

  sample_t          cic_sample;
  logic             cic_valid;

  // Free-running bit-period counter.
  always_comb begin
    cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  // Divider, bit clock and input synchroniser. The bit clock is registered
  // from cnt_next so that it is high exactly while cnt is in the upper half
  // of the period, with no combinational path to the pin. pdm_in comes from
  // another clock domain, so it passes through two flops before use.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt         <= '0;
      pdm_clk_out <= 1'b0;
      pdm_meta    <= 1'b0;
      pdm_sync    <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      pdm_clk_out <= (cnt_next >= CNT_HALF);
      pdm_meta    <= pdm_in;
      pdm_sync    <= pdm_meta;
    end
  end

  // The microphone changes its data after the rising bit-clock edge, so
  // the bit is taken on the last cycle of the low phase, when it has had
  // the whole low half-period to settle through the synchroniser.
  assign bit_strobe = (cnt == CNT_STROBE);

  pdm_cic_decimator #(
    .DECIM (DECIM)
  ) u_cic (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .bit_strobe       (bit_strobe),
    .bit_value        (pdm_sync),
    .sample_out       (cic_sample),
    .sample_valid_out (cic_valid)
  );

`ifdef PDM_DECIMATOR_DCBLOCK_EN

  localparam logic signed [23:0] DC_SAT_HI = 24'sd32767;
  localparam logic signed [23:0] DC_SAT_LO = -24'sd32768;

  logic signed [23:0] dc_x;
  logic signed [23:0] dc_y;
  logic signed [23:0] dc_x_prev;
  logic signed [23:0] dc_y_prev;
  sample_t            dc_sat;

  // DC blocker recurrence with a pole at 1 - 1/256. The 24-bit state keeps
  // headroom for the step response, which can briefly exceed 16 bits; only
  // the output is clamped, the fed-back y_prev stays unsaturated so the
  // filter state remains linear.
  always_comb begin
    dc_x = {{8{cic_sample[15]}}, cic_sample};
    dc_y = dc_x - dc_x_prev + dc_y_prev - (dc_y_prev >>> 8);
    if (dc_y > DC_SAT_HI) begin
      dc_sat = 16'sh7FFF;
    end else if (dc_y < DC_SAT_LO) begin
      dc_sat = 16'sh8000;
    end else begin
      dc_sat = dc_y[15:0];
    end
  end

  // The blocker advances once per CIC sample and adds one register stage,
  // so the valid strobe follows the CIC strobe by one cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dc_x_prev        <= '0;
      dc_y_prev        <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= cic_valid;
      if (cic_valid) begin
        dc_x_prev  <= dc_x;
        dc_y_prev  <= dc_y;
        sample_out <= dc_sat;
      end
    end
  end

`else

  // Without the DC blocker the CIC output register drives the pins
  // directly.
  assign sample_out       = cic_sample;
  assign sample_valid_out = cic_valid;

`endif

endmodule

// File: tb/tb_pdm_decimator.sv
// ---------------------------------------------------------------------------
// tb_pdm_decimator
//
// Self-checking bench for pdm_decimator at default parameters. Each test
// task applies reset, selects how pdm_in is driven on every new PDM bit,
// pushes the samples it expects onto a scoreboard queue, collects the DUT
// samples and pops the queue to compare.
// ---------------------------------------------------------------------------
module tb_pdm_decimator;

  localparam int CLK_DIV = 16;
  localparam int DECIM   = 64;
  localparam int PERIOD  = CLK_DIV * DECIM;
`ifdef PDM_DECIMATOR_DCBLOCK_EN
  localparam int LATENCY = 3;
`else
  localparam int LATENCY = 2;
`endif
  // Cycle (counted from reset release, cnt = 0 on cycle 0) on which the
  // first valid is visible: first bit strobe at cnt = CLK_DIV/2-1, the
  // 64th strobe closes the period, then the pipeline latency.
  localparam int FIRST_VALID = (CLK_DIV / 2 - 1) + (DECIM - 1) * CLK_DIV + LATENCY;

  localparam int MODE_ZERO = 0;
  localparam int MODE_ONE  = 1;
  localparam int MODE_ALT  = 2;
  localparam int MODE_MOD  = 3;

  typedef struct {
    int idx;
    int exp;
    int tol;
  } exp_t;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               pdm_in = 1'b0;
  logic               pdm_clk_out;
  logic signed [15:0] sample_out;
  logic               sample_valid_out;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   drive_mode = MODE_ZERO;
  int   mod_acc = 0;
  logic pclk_prev = 1'b0;
  exp_t sb[$];
  int   actual[$];

  pdm_decimator #(
    .CLK_DIV (CLK_DIV),
    .DECIM   (DECIM)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pdm_in           (pdm_in),
    .pdm_clk_out      (pdm_clk_out),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out)
  );

  always #5 clk_in = ~clk_in;

  // Produce the next PDM bit; the modulator is a first-order sigma-delta
  // at level 16384 of a +/-32768 full scale (ones density 0.75).
  task automatic next_bit();
    case (drive_mode)
      MODE_ZERO: pdm_in = 1'b0;
      MODE_ONE:  pdm_in = 1'b1;
      MODE_ALT:  pdm_in = ~pdm_in;
      default: begin
        pdm_in  = (mod_acc >= 0);
        mod_acc = mod_acc + 16384 - (pdm_in ? 32768 : -32768);
      end
    endcase
  endtask

  // Advance one clock, sample #1 after the edge, and present a new PDM
  // bit after each rising edge of the bit clock, as a microphone would.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    if (pdm_clk_out && !pclk_prev) next_bit();
    pclk_prev = pdm_clk_out;
  endtask

  task automatic apply_reset(input int mode, input int n);
    drive_mode = mode;
    mod_acc    = 0;
    pdm_in     = 1'b0;
    rst_in     = 1'b1;
    repeat (n) step();
    next_bit();
    rst_in    = 1'b0;
    pclk_prev = 1'b0;
    cyc       = 0;
  endtask

  task automatic collect(input int n, input int budget);
    int waited = 0;
    actual.delete();
    while (actual.size() < n && waited < budget) begin
      step();
      waited++;
      if (sample_valid_out) actual.push_back(int'(sample_out));
    end
  endtask

  task automatic test_reset();
    drive_mode = MODE_ONE;
    rst_in = 1'b1;
    step();
    checks++;
    if (pdm_clk_out !== 1'b0 || sample_out !== 16'sd0 || sample_valid_out !== 1'b0)
      $display("[TB] FAIL reset_outputs: clk=%b sample=%0d valid=%b, expected 0/0/0",
               pdm_clk_out, sample_out, sample_valid_out);
    else passed++;
  endtask

  task automatic test_timing();
    int next_valid = FIRST_VALID;
    int nvalid = 0;
    apply_reset(MODE_ONE, 3);
    for (int c = 0; c <= FIRST_VALID + 2 * PERIOD + 5; c++) begin
      if (c > 0) step();
      if (c < 3 * CLK_DIV) begin
        checks++;
        if (pdm_clk_out !== ((c % CLK_DIV) >= CLK_DIV / 2))
          $display("[TB] FAIL pdm_clk cycle %0d: got %b, expected %b",
                   c, pdm_clk_out, ((c % CLK_DIV) >= CLK_DIV / 2));
        else passed++;
      end
      if (sample_valid_out) begin
        nvalid++;
        checks++;
        if (c !== next_valid)
          $display("[TB] FAIL valid_timing: strobe at cycle %0d, expected %0d", c, next_valid);
        else passed++;
        next_valid = next_valid + PERIOD;
      end
    end
    checks++;
    if (nvalid !== 3) $display("[TB] FAIL valid_count: got %0d strobes, expected 3", nvalid);
    else passed++;
  endtask

  task automatic test_constant(input logic val);
    exp_t e;
    int   nvalid = 0;
    sb.delete();
    for (int i = 4; i <= 6; i++) sb.push_back('{i, (val ? 32767 : -32768), 0});
    apply_reset(val ? MODE_ONE : MODE_ZERO, 3);
    collect(6, 8 * PERIOD);
    checks++;
    if (actual.size() !== 6) $display("[TB] FAIL const%0d_timeout: got %0d samples, expected 6", val, actual.size());
    else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.idx <= actual.size()) begin
        checks++;
        if (actual[e.idx-1] > e.exp + e.tol || actual[e.idx-1] < e.exp - e.tol)
          $display("[TB] FAIL const%0d_sample%0d: got %0d, expected %0d", val, e.idx, actual[e.idx-1], e.exp);
        else passed++;
      end
    end
    for (int c = 0; c < 100; c++) begin
      step();
      if (sample_valid_out) nvalid++;
    end
    checks++;
    if (sample_out !== (val ? 16'sd32767 : -16'sd32768) || nvalid !== 0)
      $display("[TB] FAIL const%0d_hold: sample=%0d strobes=%0d, expected %0d and 0",
               val, sample_out, nvalid, (val ? 32767 : -32768));
    else passed++;
  endtask

  task automatic test_alternating();
    exp_t e;
    sb.delete();
    for (int i = 4; i <= 6; i++) sb.push_back('{i, 0, 1});
    apply_reset(MODE_ALT, 3);
    collect(6, 8 * PERIOD);
    checks++;
    if (actual.size() !== 6) $display("[TB] FAIL alt_timeout: got %0d samples, expected 6", actual.size());
    else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.idx <= actual.size()) begin
        checks++;
        if (actual[e.idx-1] > e.exp + e.tol || actual[e.idx-1] < e.exp - e.tol)
          $display("[TB] FAIL alt_sample%0d: got %0d, expected %0d +/- %0d", e.idx, actual[e.idx-1], e.exp, e.tol);
        else passed++;
      end
    end
  endtask

  task automatic test_modulator();
    exp_t e;
    int   sum = 0;
    sb.delete();
    sb.push_back('{39, 16384, 256});
    apply_reset(MODE_MOD, 3);
    collect(39, 41 * PERIOD);
    checks++;
    if (actual.size() !== 39) $display("[TB] FAIL mod_timeout: got %0d samples, expected 39", actual.size());
    else passed++;
    e = sb.pop_front();
    if (actual.size() >= e.idx) begin
      for (int i = 7; i < e.idx; i++) sum += actual[i];
      sum = sum / (e.idx - 7);
      checks++;
      if (sum > e.exp + e.tol || sum < e.exp - e.tol)
        $display("[TB] FAIL mod_mean: got %0d, expected %0d +/- %0d", sum, e.exp, e.tol);
      else passed++;
    end
  endtask

  task automatic test_midreset();
    int first = -1;
    apply_reset(MODE_ONE, 3);
    collect(4, 6 * PERIOD);
    repeat (500) step();
    checks++;
    if (sample_out === 16'sd0) $display("[TB] FAIL midreset_precondition: got sample 0, expected nonzero");
    else passed++;
    rst_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (pdm_clk_out !== 1'b0 || sample_out !== 16'sd0 || sample_valid_out !== 1'b0)
        $display("[TB] FAIL midreset_cycle%0d: clk=%b sample=%0d valid=%b, expected 0/0/0",
                 c, pdm_clk_out, sample_out, sample_valid_out);
      else passed++;
    end
    rst_in    = 1'b0;
    pclk_prev = 1'b0;
    cyc       = 0;
    for (int c = 0; c <= FIRST_VALID + 20 && first < 0; c++) begin
      if (c > 0) step();
      if (sample_valid_out) first = c;
    end
    checks++;
    if (first !== FIRST_VALID)
      $display("[TB] FAIL midreset_next_strobe: got cycle %0d, expected %0d", first, FIRST_VALID);
    else passed++;
  endtask

`ifdef PDM_DECIMATOR_DCBLOCK_EN
  task automatic test_dcblock();
    int peak = -40000;
    apply_reset(MODE_ONE, 3);
    collect(12, 14 * PERIOD);
    checks++;
    if (actual.size() !== 12) $display("[TB] FAIL dc_timeout: got %0d samples, expected 12", actual.size());
    else passed++;
    if (actual.size() == 12) begin
      for (int i = 0; i < 6; i++) if (actual[i] > peak) peak = actual[i];
      checks++;
      if (peak <= 30000) $display("[TB] FAIL dc_peak: got %0d, expected above 30000", peak);
      else passed++;
      checks++;
      if (actual[11] >= actual[5]) $display("[TB] FAIL dc_decay: got %0d, expected below %0d", actual[11], actual[5]);
      else passed++;
    end
  endtask
`endif

  initial begin
    $display("[TB] pdm_decimator bench start");
    test_reset();
    test_timing();
`ifdef PDM_DECIMATOR_DCBLOCK_EN
    test_dcblock();
`else
    test_constant(1'b1);
    test_constant(1'b0);
    test_alternating();
    test_modulator();
`endif
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
